// File: rtl/fft_iter_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fft_iter_pkg
// Purpose  : Shared types and address arithmetic for the iterative radix-2
//            DIT FFT sequencer (state encoding, size clamp, stage addressing).
// Revision : 1.0  initial release
// ============================================================================
package fft_iter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } seq_state_e;

  // Requested log2(N) limited to the supported range 1..max_l.
  function automatic logic [31:0] clamp_log2n(input logic [31:0] req,
                                               input logic [31:0] max_l);
    if (req < 32'd1) return 32'd1;
    if (req > max_l) return max_l;
    return req;
  endfunction

  // Upper operand index of butterfly bf in stage lay: the group index is
  // spread over 2^(lay+1) words, the position inside the group is kept.
  function automatic logic [31:0] stage_addr_a(input logic [31:0] bf,
                                               input logic [31:0] lay);
    logic [31:0] pos_mask;
    pos_mask = (32'd1 << lay) - 32'd1;
    return ((bf >> lay) << (lay + 32'd1)) | (bf & pos_mask);
  endfunction

  // Lower operand sits half a group (2^lay words) above the upper one.
  function automatic logic [31:0] stage_addr_b(input logic [31:0] bf,
                                               input logic [31:0] lay);
    return stage_addr_a(bf, lay) + (32'd1 << lay);
  endfunction

  // Twiddle index into the full 2^awl-point table, independent of N.
  function automatic logic [31:0] stage_twiddle(input logic [31:0] bf,
                                                input logic [31:0] lay,
                                                input logic [31:0] awl);
    logic [31:0] pos_mask;
    pos_mask = (32'd1 << lay) - 32'd1;
    return (bf & pos_mask) << (awl - 32'd1 - lay);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fft_iter_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fft_iter_sequencer_if
// Purpose  : Control/address bundle between the FFT sequencer and its user
//            (request side, work-RAM ports, twiddle and stage indicators).
// Revision : 1.0  initial release
// ============================================================================
interface fft_iter_sequencer_if #(
  parameter int AWL   = 5,
  parameter int LayWL = 3
);
  logic             EN;
  logic             START;
  logic [LayWL-1:0] i_LOG2N;
  logic             i_INVERSE;
  logic             BUSY;
  logic             DONE;
  logic             RD_EN;
  logic [AWL-1:0]   RD_A_ADDR;
  logic [AWL-1:0]   RD_B_ADDR;
  logic [AWL-2:0]   W_ADDR;
  logic             W_CONJ;
  logic             WR_EN;
  logic [AWL-1:0]   WR_A_ADDR;
  logic [AWL-1:0]   WR_B_ADDR;
  logic [LayWL-1:0] LAY_NUM;
  logic             FIRST_LAY;
  logic             LAST_LAY;

  modport master (
    output EN, START, i_LOG2N, i_INVERSE,
    input  BUSY, DONE, RD_EN, RD_A_ADDR, RD_B_ADDR, W_ADDR, W_CONJ,
           WR_EN, WR_A_ADDR, WR_B_ADDR, LAY_NUM, FIRST_LAY, LAST_LAY
  );

  modport slave (
    input  EN, START, i_LOG2N, i_INVERSE,
    output BUSY, DONE, RD_EN, RD_A_ADDR, RD_B_ADDR, W_ADDR, W_CONJ,
           WR_EN, WR_A_ADDR, WR_B_ADDR, LAY_NUM, FIRST_LAY, LAST_LAY
  );
endinterface
`default_nettype wire

// File: rtl/fft_addr_delay_line.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fft_addr_delay_line
// Purpose  : DEPTH-stage shift register carrying {valid, a_addr, b_addr} from
//            the read issue point to the write-back point.
// Revision : 1.0  initial release
// ============================================================================
module fft_addr_delay_line #(
  parameter int DEPTH = 4,
  parameter int AWL   = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en_i,
  input  logic           vld_i,
  input  logic [AWL-1:0] a_i,
  input  logic [AWL-1:0] b_i,
  output logic           vld_o,
  output logic [AWL-1:0] a_o,
  output logic [AWL-1:0] b_o
);

  logic [2*AWL:0] ent_q [DEPTH];

  // Shift one entry per enabled clock; reset empties the whole line.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else if (en_i) begin
      ent_q[0] <= {vld_i, a_i, b_i};
      for (int i = 1; i < DEPTH; i++) ent_q[i] <= ent_q[i-1];
    end
  end

  assign vld_o = ent_q[DEPTH-1][2*AWL];
  assign a_o   = ent_q[DEPTH-1][2*AWL-1:AWL];
  assign b_o   = ent_q[DEPTH-1][AWL-1:0];

endmodule
`default_nettype wire

// File: rtl/fft_iter_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fft_iter_sequencer
// Purpose  : Control and address sequencer for an in-place radix-2 DIT FFT
//            with run-time size, inverse flag, issue interval and draining.
// Revision : 1.0  initial release
// ============================================================================
module fft_iter_sequencer
  import fft_iter_pkg::*;
#(
  parameter int AWL           = 5,
  parameter int LayWL         = 3,
  parameter int BUT_CLK_CYCLE = 1,
  parameter int PIPE_LAT      = 4
) (
  input  logic CLK,
  input  logic RST,
  fft_iter_sequencer_if.slave bus
);

  localparam int JW = AWL - 1;
  localparam int TW = (BUT_CLK_CYCLE > 1) ? $clog2(BUT_CLK_CYCLE) : 1;
  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [TW-1:0]    TICK_LAST  = TW'(BUT_CLK_CYCLE - 1);
  localparam logic [DW-1:0]    DRAIN_LAST = DW'(PIPE_LAT - 1);
  localparam logic [TW-1:0]    TICK_ONE   = TW'(1);
  localparam logic [DW-1:0]    DRAIN_ONE  = DW'(1);
  localparam logic [JW-1:0]    BF_ONE     = JW'(1);
  localparam logic [LayWL-1:0] LAY_ONE    = LayWL'(1);

  seq_state_e       state_q, state_d;
  logic [LayWL-1:0] lay_q, lay_d;     // current stage s
  logic [LayWL-1:0] l_q, l_d;         // number of stages L
  logic [JW-1:0]    bf_q, bf_d;       // butterfly index j
  logic [TW-1:0]    tick_q, tick_d;   // clocks since last issue
  logic [DW-1:0]    drn_q, drn_d;     // clocks spent draining
  logic             inv_q, inv_d;
  logic [AWL-1:0]   rda_q, rdb_q;
  logic [JW-1:0]    tw_q;

  logic             w_issue;
  logic [AWL-1:0]   w_rd_a, w_rd_b;
  logic [JW-1:0]    w_tw, w_last_bf;
  logic             w_last_lay, w_busy;
  logic             w_wr_en;
  logic [AWL-1:0]   w_wr_a, w_wr_b;

  assign w_issue    = (state_q == ST_ISSUE) && (tick_q == '0);
  assign w_rd_a     = AWL'(stage_addr_a(32'(bf_q), 32'(lay_q)));
  assign w_rd_b     = AWL'(stage_addr_b(32'(bf_q), 32'(lay_q)));
  assign w_tw       = JW'(stage_twiddle(32'(bf_q), 32'(lay_q), 32'(AWL)));
  assign w_last_bf  = JW'((32'd1 << (l_q - LAY_ONE)) - 32'd1);
  assign w_last_lay = (lay_q == (l_q - LAY_ONE));
  assign w_busy     = (state_q != ST_IDLE);

  // State, counters and latched setup advance only on enabled clocks.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      lay_q   <= '0;
      l_q     <= '0;
      bf_q    <= '0;
      tick_q  <= '0;
      drn_q   <= '0;
      inv_q   <= 1'b0;
    end else if (bus.EN) begin
      state_q <= state_d;
      lay_q   <= lay_d;
      l_q     <= l_d;
      bf_q    <= bf_d;
      tick_q  <= tick_d;
      drn_q   <= drn_d;
      inv_q   <= inv_d;
    end
  end

  // Next-state: issue N/2 butterflies, drain the pipe, repeat per stage.
  always_comb begin
    state_d = state_q;
    lay_d   = lay_q;
    l_d     = l_q;
    bf_d    = bf_q;
    tick_d  = tick_q;
    drn_d   = drn_q;
    inv_d   = inv_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.START) begin
          state_d = ST_ISSUE;
          l_d     = LayWL'(clamp_log2n(32'(bus.i_LOG2N), 32'(AWL)));
          inv_d   = bus.i_INVERSE;
          lay_d   = '0;
          bf_d    = '0;
          tick_d  = '0;
          drn_d   = '0;
        end
      end
      ST_ISSUE: begin
        if (w_issue && (bf_q == w_last_bf)) begin
          state_d = ST_DRAIN;
          tick_d  = '0;
          drn_d   = '0;
        end else begin
          if (w_issue) bf_d = bf_q + BF_ONE;
          tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + TICK_ONE;
        end
      end
      ST_DRAIN: begin
        // Leaving on the clock of the stage's last write keeps the next
        // stage's first read strictly after it.
        if (drn_q == DRAIN_LAST) begin
          if (w_last_lay) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_ISSUE;
            lay_d   = lay_q + LAY_ONE;
            bf_d    = '0;
            tick_d  = '0;
          end
        end else begin
          drn_d = drn_q + DRAIN_ONE;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        lay_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read-side addresses hold the last issued butterfly between strobes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rda_q <= '0;
      rdb_q <= '0;
      tw_q  <= '0;
    end else if (bus.EN && w_issue) begin
      rda_q <= w_rd_a;
      rdb_q <= w_rd_b;
      tw_q  <= w_tw;
    end
  end

  assign bus.RD_EN     = w_issue;
  assign bus.RD_A_ADDR = w_issue ? w_rd_a : rda_q;
  assign bus.RD_B_ADDR = w_issue ? w_rd_b : rdb_q;
  assign bus.W_ADDR    = w_issue ? w_tw : tw_q;

  // Write-back addresses are the visible read addresses PIPE_LAT clocks
  // later, so they inherit the hold behaviour without extra registers.
  fft_addr_delay_line #(
    .DEPTH (PIPE_LAT),
    .AWL   (AWL)
  ) u_dly (
    .clk   (CLK),
    .rst   (RST),
    .en_i  (bus.EN),
    .vld_i (w_issue),
    .a_i   (bus.RD_A_ADDR),
    .b_i   (bus.RD_B_ADDR),
    .vld_o (w_wr_en),
    .a_o   (w_wr_a),
    .b_o   (w_wr_b)
  );

  assign bus.WR_EN     = w_wr_en;
  assign bus.WR_A_ADDR = w_wr_a;
  assign bus.WR_B_ADDR = w_wr_b;
  assign bus.BUSY      = w_busy;
  assign bus.DONE      = (state_q == ST_FIN);
  assign bus.W_CONJ    = inv_q;
  assign bus.LAY_NUM   = lay_q;
  assign bus.FIRST_LAY = w_busy && (lay_q == '0);
  assign bus.LAST_LAY  = w_busy && w_last_lay;

endmodule
`default_nettype wire

// File: tb/tb_fft_iter_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fft_iter_sequencer
// Purpose  : Self-checking bench; two sequencers (issue interval 1 and 3)
//            share stimulus and are compared against a timing/address model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fft_iter_sequencer;

  localparam int AWL = 5;
  localparam int LW  = 3;
  localparam int PL  = 3;

  typedef struct packed {
    logic busy, done, rd_en, wr_en, conj, first, last;
    logic [LW-1:0]  lay;
    logic [AWL-1:0] a, b;
    logic [AWL-2:0] w;
    logic [AWL-1:0] wa, wb;
  } obs_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] log2n = '0;
  logic          inv = 1'b0;

  always #5 clk = ~clk;

  fft_iter_sequencer_if #(.AWL(AWL), .LayWL(LW)) bus1 ();
  fft_iter_sequencer_if #(.AWL(AWL), .LayWL(LW)) bus3 ();

  assign bus1.EN = en;  assign bus1.START = start;
  assign bus1.i_LOG2N = log2n;  assign bus1.i_INVERSE = inv;
  assign bus3.EN = en;  assign bus3.START = start;
  assign bus3.i_LOG2N = log2n;  assign bus3.i_INVERSE = inv;

  fft_iter_sequencer #(.AWL(AWL), .LayWL(LW), .BUT_CLK_CYCLE(1), .PIPE_LAT(PL))
    u_dut1 (.CLK(clk), .RST(rst), .bus(bus1.slave));
  fft_iter_sequencer #(.AWL(AWL), .LayWL(LW), .BUT_CLK_CYCLE(3), .PIPE_LAT(PL))
    u_dut3 (.CLK(clk), .RST(rst), .bus(bus3.slave));

  obs_t o1, o3;
  assign o1 = {bus1.BUSY, bus1.DONE, bus1.RD_EN, bus1.WR_EN, bus1.W_CONJ,
               bus1.FIRST_LAY, bus1.LAST_LAY, bus1.LAY_NUM, bus1.RD_A_ADDR,
               bus1.RD_B_ADDR, bus1.W_ADDR, bus1.WR_A_ADDR, bus1.WR_B_ADDR};
  assign o3 = {bus3.BUSY, bus3.DONE, bus3.RD_EN, bus3.WR_EN, bus3.W_CONJ,
               bus3.FIRST_LAY, bus3.LAST_LAY, bus3.LAY_NUM, bus3.RD_A_ADDR,
               bus3.RD_B_ADDR, bus3.W_ADDR, bus3.WR_A_ADDR, bus3.WR_B_ADDR};

  int n_chk = 0;
  int n_err = 0;
  int cur_t = 0;
  // Read-side values held from the previous transform, per DUT (0: bcc 1, 1: bcc 3).
  int pa[2], pb[2], pw[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s t=%0d got=%0d want=%0d", tag, cur_t, got, want);
    end
  endtask

  function automatic int clamp_l(input int v);
    return (v < 1) ? 1 : ((v > AWL) ? AWL : v);
  endfunction

  function automatic int stage_len(input int bcc, input int L);
    return ((2 ** (L - 1)) - 1) * bcc + 1 + PL;
  endfunction

  // Read port as seen in EN-clock t after START (t>=1), including hold.
  function automatic void rd_at(input int t, input int bcc, input int L,
                                input int ha, input int hb, input int hw,
                                output bit ren, output int a, output int b, output int w);
    int nh, d, s, off, j, pos, grp;
    nh = 2 ** (L - 1);
    d  = stage_len(bcc, L);
    if (t < 1) begin
      ren = 0; a = ha; b = hb; w = hw;
      return;
    end
    s   = (t - 1) / d;
    off = (t - 1) % d;
    if (s >= L) begin s = L - 1; off = d - 1; end
    if (off > (nh - 1) * bcc) begin
      j = nh - 1; ren = 0;
    end else begin
      j = off / bcc; ren = ((off % bcc) == 0);
    end
    pos = j % (2 ** s);
    grp = j / (2 ** s);
    a = grp * (2 ** (s + 1)) + pos;
    b = a + 2 ** s;
    w = pos * (2 ** (AWL - 1 - s));
  endfunction

  function automatic obs_t model(input int t, input int bcc, input int L, input bit inv_f,
                                 input int ha, input int hb, input int hw);
    obs_t e;
    bit ren, wen;
    int a, b, w, wa, wb, wd, d, tot, s;
    d   = stage_len(bcc, L);
    tot = L * d + 1;
    rd_at(t, bcc, L, ha, hb, hw, ren, a, b, w);
    rd_at(t - PL, bcc, L, ha, hb, hw, wen, wa, wb, wd);
    s = (t - 1) / d;
    if (s > L - 1) s = L - 1;
    e = '0;
    e.busy  = (t >= 1) && (t <= tot);
    e.done  = (t == tot);
    e.rd_en = ren;
    e.wr_en = wen;
    e.conj  = inv_f;
    e.lay   = e.busy ? LW'(s) : '0;
    e.first = e.busy && (s == 0);
    e.last  = e.busy && (s == L - 1);
    e.a  = AWL'(a);  e.b  = AWL'(b);  e.w = (AWL-1)'(w);
    e.wa = AWL'(wa); e.wb = AWL'(wb);
    return e;
  endfunction

  task automatic check_obs(input string nm, input obs_t o, input obs_t e);
    chk({nm, ".busy"},  32'(o.busy),  32'(e.busy));
    chk({nm, ".done"},  32'(o.done),  32'(e.done));
    chk({nm, ".rd_en"}, 32'(o.rd_en), 32'(e.rd_en));
    chk({nm, ".wr_en"}, 32'(o.wr_en), 32'(e.wr_en));
    chk({nm, ".conj"},  32'(o.conj),  32'(e.conj));
    chk({nm, ".first"}, 32'(o.first), 32'(e.first));
    chk({nm, ".last"},  32'(o.last),  32'(e.last));
    chk({nm, ".lay"},   32'(o.lay),   32'(e.lay));
    chk({nm, ".rd_a"},  32'(o.a),     32'(e.a));
    chk({nm, ".rd_b"},  32'(o.b),     32'(e.b));
    chk({nm, ".w"},     32'(o.w),     32'(e.w));
    chk({nm, ".wr_a"},  32'(o.wa),    32'(e.wa));
    chk({nm, ".wr_b"},  32'(o.wb),    32'(e.wb));
  endtask

  // One transform on both DUTs. ws/wl: EN-low window (wall cycles), sp: wall
  // cycle of a START pulse while busy, rst_at: wall cycle of an abort reset.
  task automatic run_xfer(input int req, input bit inv_req, input int ws, input int wl,
                          input int sp, input int rst_at);
    int L, t, c;
    int tot[2], done_c[2], bcc[2];
    bit wen;
    int fa, fb, fw;
    bcc[0] = 1; bcc[1] = 3;
    L = clamp_l(req);
    for (int k = 0; k < 2; k++) begin
      tot[k] = L * stage_len(bcc[k], L) + 1;
      done_c[k] = -1;
    end
    @(negedge clk);
    en = 1'b1; start = 1'b1; log2n = LW'(req); inv = inv_req;
    @(posedge clk);
    t = 1; c = 1;
    while (t <= tot[1] + PL + 3 && c < 800) begin
      @(negedge clk);
      cur_t = t;
      start = 1'b0;
      check_obs("d1", o1, model(t, 1, L, inv_req, pa[0], pb[0], pw[0]));
      check_obs("d3", o3, model(t, 3, L, inv_req, pa[1], pb[1], pw[1]));
      if (o1.done === 1'b1 && done_c[0] < 0) done_c[0] = c;
      if (o3.done === 1'b1 && done_c[1] < 0) done_c[1] = c;
      log2n = LW'($urandom);
      inv   = 1'($urandom);
      if (rst_at > 0 && c == rst_at) begin
        rst = 1'b1;
        @(posedge clk);
        for (int k = 0; k < PL + 4; k++) begin
          @(negedge clk);
          rst = 1'b0;
          cur_t = -1;
          check_obs("d1.rst", o1, '0);
          check_obs("d3.rst", o3, '0);
        end
        for (int k = 0; k < 2; k++) begin pa[k] = 0; pb[k] = 0; pw[k] = 0; end
        return;
      end
      if (sp > 0 && c == sp) start = 1'b1;
      en = !(wl > 0 && c >= ws && c < ws + wl);
      @(posedge clk);
      if (en) t++;
      c++;
    end
    en = 1'b1;
    cur_t = t;
    for (int k = 0; k < 2; k++) begin
      chk((k == 0) ? "d1.done_cyc" : "d3.done_cyc", 32'(done_c[k]),
          32'(tot[k] + ((wl > 0 && ws < tot[k]) ? wl : 0)));
      rd_at(tot[k], bcc[k], L, pa[k], pb[k], pw[k], wen, fa, fb, fw);
      pa[k] = fa; pb[k] = fb; pw[k] = fw;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog t=%0d", cur_t);
    $fatal(1, "simulation time limit");
  end

  initial begin
    int req, tot1, ws, wl, sp;
    for (int k = 0; k < 2; k++) begin pa[k] = 0; pb[k] = 0; pw[k] = 0; end
    rst = 1'b1; en = 1'b1; start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_obs("d1.reset", o1, '0);
    check_obs("d3.reset", o3, '0);
    rst = 1'b0;

    run_xfer(3, 1'b0, 0, 0, 0, 0);    // 8 points, DONE at 22 / 40
    run_xfer(2, 1'b1, 0, 0, 0, 0);    // 4 points, inverse
    run_xfer(0, 1'b0, 0, 0, 0, 0);    // clamped up to one stage
    run_xfer(7, 1'b1, 0, 0, 0, 0);    // clamped down to AWL stages
    run_xfer(4, 1'b0, 12, 5, 6, 0);   // EN low 5 clocks, START while busy
    run_xfer(3, 1'b1, 0, 0, 0, 10);   // abort with RST at cycle 10
    run_xfer(3, 1'b0, 0, 0, 0, 0);    // clean run after abort

    for (int i = 0; i < 6; i++) begin
      req  = int'($urandom_range(0, 7));
      tot1 = clamp_l(req) * stage_len(1, clamp_l(req)) + 1;
      ws   = int'($urandom_range(1, tot1 - 1));
      wl   = int'($urandom_range(1, 6));
      sp   = int'($urandom_range(1, tot1 - 1));
      run_xfer(req, 1'($urandom), ws, wl, sp, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
